// File: rtl/pending_instr_tracker_if.sv
// Dispatch/retire event bus into the pending-instruction tracker and its status outputs.
interface pending_instr_tracker_if #(
   parameter int unsigned NUM_WARPS   = 4,
   parameter int unsigned ISSUE_WIDTH = 1,
   parameter int unsigned CTR_WIDTH   = 6
);
   localparam int unsigned NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned TOT_WIDTH = CTR_WIDTH + NW_WIDTH;

   logic [ISSUE_WIDTH-1:0]          issue_valid;
   logic [ISSUE_WIDTH*NW_WIDTH-1:0] issue_wid;
   logic [ISSUE_WIDTH-1:0]          committed;
   logic [ISSUE_WIDTH*NW_WIDTH-1:0] committed_wid;

   logic [NUM_WARPS-1:0]            pending;
   logic [NUM_WARPS-1:0]            full;
   logic                            drained;
   logic [TOT_WIDTH-1:0]            total_pending;
   logic                            error;

   // Issue/commit side: drives events, observes tracker status
   modport master (
      output issue_valid, issue_wid, committed, committed_wid,
      input  pending, full, drained, total_pending, error
   );

   // Tracker side
   modport slave (
      input  issue_valid, issue_wid, committed, committed_wid,
      output pending, full, drained, total_pending, error
   );
endinterface

// File: rtl/pending_instr_tracker.sv
// Per-warp saturating in-flight instruction counters with pending/full/drained
// status decoded from the counter registers only.
module pending_instr_tracker #(
   parameter int unsigned NUM_WARPS   = 4,
   parameter int unsigned ISSUE_WIDTH = 1,
   parameter int unsigned CTR_WIDTH   = 6
) (
   input logic                   clk,
   input logic                   reset,
   pending_instr_tracker_if.slave bus
);
   localparam int unsigned NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned TOT_WIDTH = CTR_WIDTH + NW_WIDTH;
   // Two extra bits: one for headroom above MAX, one as sign for underflow
   localparam int unsigned SUM_WIDTH = CTR_WIDTH + 2;
   localparam int unsigned MAX       = (1 << CTR_WIDTH) - 1;
   localparam int unsigned FULL_THR  = MAX - ISSUE_WIDTH;

   logic [CTR_WIDTH-1:0] counter_q [NUM_WARPS];
   logic [CTR_WIDTH-1:0] counter_d [NUM_WARPS];
   logic                 error_q;
   logic                 error_d;

   logic [NUM_WARPS-1:0] pending_c;
   logic [NUM_WARPS-1:0] full_c;
   logic [TOT_WIDTH-1:0] total_c;

   // State registers; reset discards every outstanding count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WARPS; w++) counter_q[w] <= '0;
         error_q <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) counter_q[w] <= counter_d[w];
         error_q <= error_d;
      end
   end

   // Next counter per warp: count lane hits, apply net change, saturate and flag
   always_comb begin
      logic [SUM_WIDTH-1:0] inc;
      logic [SUM_WIDTH-1:0] dec;
      logic [SUM_WIDTH-1:0] nxt;
      error_d = error_q;
      inc     = '0;
      dec     = '0;
      nxt     = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc = '0;
         dec = '0;
         // Out-of-range warp ids never match any w, so they are dropped silently
         for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (bus.issue_valid[i] &&
                (bus.issue_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)))
               inc = inc + SUM_WIDTH'(1);
            if (bus.committed[i] &&
                (bus.committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)))
               dec = dec + SUM_WIDTH'(1);
         end
         nxt          = SUM_WIDTH'(counter_q[w]) + inc - dec;
         counter_d[w] = nxt[CTR_WIDTH-1:0];
         if (nxt[SUM_WIDTH-1]) begin
            counter_d[w] = '0;
            error_d      = 1'b1;
         end else if (nxt > SUM_WIDTH'(MAX)) begin
            counter_d[w] = CTR_WIDTH'(MAX);
            error_d      = 1'b1;
         end
      end
   end

   // Status decode from counter registers
   always_comb begin
      pending_c = '0;
      full_c    = '0;
      total_c   = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         pending_c[w] = |counter_q[w];
         full_c[w]    = counter_q[w] > CTR_WIDTH'(FULL_THR);
         total_c      = total_c + TOT_WIDTH'(counter_q[w]);
      end
   end

   assign bus.pending       = pending_c;
   assign bus.full          = full_c;
   assign bus.drained       = ~|pending_c;
   assign bus.total_pending = total_c;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_pending_instr_tracker.sv
// Directed bench: DUT a (4 warps, 1 lane, 6-bit) and DUT b (4 warps, 2 lanes, 3-bit).
module tb_pending_instr_tracker;
   logic clk;
   logic reset;
   int   checks;
   int   passed;

   pending_instr_tracker_if #(.NUM_WARPS(4), .ISSUE_WIDTH(1), .CTR_WIDTH(6)) ifa ();
   pending_instr_tracker_if #(.NUM_WARPS(4), .ISSUE_WIDTH(2), .CTR_WIDTH(3)) ifb ();

   pending_instr_tracker #(.NUM_WARPS(4), .ISSUE_WIDTH(1), .CTR_WIDTH(6)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   pending_instr_tracker #(.NUM_WARPS(4), .ISSUE_WIDTH(2), .CTR_WIDTH(3)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      ifa.issue_valid = '0; ifa.issue_wid = '0; ifa.committed = '0; ifa.committed_wid = '0;
      ifb.issue_valid = '0; ifb.issue_wid = '0; ifb.committed = '0; ifb.committed_wid = '0;
   endtask

   task automatic pulse_reset;
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      step();
   endtask

   task automatic test_reset;
      idle_inputs();
      reset = 1'b0;
      #3;
      checks++;
      if (ifa.drained !== 1'b1 || ifa.pending !== 4'b0000 || ifa.total_pending !== 8'd0 ||
          ifa.error !== 1'b0 || ifa.full !== 4'b0000)
         $display("FAIL reset_a: drained=%b pending=%b total=%0d error=%b full=%b, expected 1 0000 0 0 0000",
                  ifa.drained, ifa.pending, ifa.total_pending, ifa.error, ifa.full);
      else passed++;
      checks++;
      if (ifb.drained !== 1'b1 || ifb.total_pending !== 5'd0 || ifb.error !== 1'b0 || ifb.full !== 4'b0000)
         $display("FAIL reset_b: drained=%b total=%0d error=%b full=%b, expected 1 0 0 0000",
                  ifb.drained, ifb.total_pending, ifb.error, ifb.full);
      else passed++;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_basic;
      ifa.issue_valid = 1'b1; ifa.issue_wid = 2'd2;
      step();
      checks++;
      if (ifa.total_pending !== 8'd1 || ifa.pending !== 4'b0100)
         $display("FAIL basic_latency: total=%0d pending=%b, expected 1 0100", ifa.total_pending, ifa.pending);
      else passed++;
      step();
      step();
      ifa.issue_valid = 1'b0;
      checks++;
      if (ifa.pending !== 4'b0100 || ifa.total_pending !== 8'd3 || ifa.drained !== 1'b0)
         $display("FAIL basic_issue3: pending=%b total=%0d drained=%b, expected 0100 3 0",
                  ifa.pending, ifa.total_pending, ifa.drained);
      else passed++;
      step();
      checks++;
      if (ifa.total_pending !== 8'd3)
         $display("FAIL basic_hold: total=%0d, expected 3", ifa.total_pending);
      else passed++;
      ifa.committed = 1'b1; ifa.committed_wid = 2'd2;
      step();
      step();
      checks++;
      if (ifa.total_pending !== 8'd1 || ifa.pending !== 4'b0100)
         $display("FAIL basic_commit2: total=%0d pending=%b, expected 1 0100", ifa.total_pending, ifa.pending);
      else passed++;
      step();
      ifa.committed = 1'b0;
      checks++;
      if (ifa.pending !== 4'b0000 || ifa.drained !== 1'b1 || ifa.total_pending !== 8'd0 || ifa.error !== 1'b0)
         $display("FAIL basic_drain: pending=%b drained=%b total=%0d error=%b, expected 0000 1 0 0",
                  ifa.pending, ifa.drained, ifa.total_pending, ifa.error);
      else passed++;
   endtask

   task automatic test_cancel_multilane;
      // both lanes to warp 1 (+2), then lane0 only (+1) -> 3
      ifb.issue_valid = 2'b11; ifb.issue_wid = 4'b0101;
      step();
      ifb.issue_valid = 2'b01;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd3 || ifb.pending !== 4'b0010)
         $display("FAIL cancel_setup: total=%0d pending=%b, expected 3 0010", ifb.total_pending, ifb.pending);
      else passed++;
      ifb.issue_valid = 2'b01; ifb.issue_wid = 4'b0001;
      ifb.committed   = 2'b01; ifb.committed_wid = 4'b0001;
      step();
      ifb.issue_valid = 2'b00; ifb.committed = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd3 || ifb.pending[1] !== 1'b1 || ifb.error !== 1'b0)
         $display("FAIL cancel_same_cycle: total=%0d pending1=%b error=%b, expected 3 1 0",
                  ifb.total_pending, ifb.pending[1], ifb.error);
      else passed++;
      ifb.issue_valid = 2'b11; ifb.issue_wid = 4'b0101;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd5 || ifb.full !== 4'b0000)
         $display("FAIL multilane_issue: total=%0d full=%b, expected 5 0000", ifb.total_pending, ifb.full);
      else passed++;
      pulse_reset();
   endtask

   task automatic test_full;
      ifb.issue_valid = 2'b11; ifb.issue_wid = 4'b0000;
      step();
      step();
      ifb.issue_valid = 2'b01;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd5 || ifb.full !== 4'b0000)
         $display("FAIL full_at5: total=%0d full=%b, expected 5 0000", ifb.total_pending, ifb.full);
      else passed++;
      ifb.issue_valid = 2'b01;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd6 || ifb.full !== 4'b0001)
         $display("FAIL full_at6: total=%0d full=%b, expected 6 0001", ifb.total_pending, ifb.full);
      else passed++;
      ifb.committed = 2'b01; ifb.committed_wid = 4'b0000;
      step();
      ifb.committed = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd5 || ifb.full !== 4'b0000 || ifb.error !== 1'b0)
         $display("FAIL full_release: total=%0d full=%b error=%b, expected 5 0000 0",
                  ifb.total_pending, ifb.full, ifb.error);
      else passed++;
      pulse_reset();
   endtask

   task automatic test_overflow;
      ifb.issue_valid = 2'b11; ifb.issue_wid = 4'b1111;
      step();
      step();
      step();
      ifb.issue_valid = 2'b01;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd7 || ifb.error !== 1'b0 || ifb.full !== 4'b1000)
         $display("FAIL ovf_setup: total=%0d error=%b full=%b, expected 7 0 1000",
                  ifb.total_pending, ifb.error, ifb.full);
      else passed++;
      ifb.issue_valid = 2'b01;
      step();
      ifb.issue_valid = 2'b00;
      checks++;
      if (ifb.total_pending !== 5'd7 || ifb.error !== 1'b1)
         $display("FAIL ovf_saturate: total=%0d error=%b, expected 7 1", ifb.total_pending, ifb.error);
      else passed++;
      ifb.committed = 2'b11; ifb.committed_wid = 4'b1111;
      step();
      step();
      step();
      ifb.committed = 2'b01;
      step();
      ifb.committed = 2'b00;
      step();
      checks++;
      if (ifb.drained !== 1'b1 || ifb.total_pending !== 5'd0 || ifb.error !== 1'b1)
         $display("FAIL ovf_sticky: drained=%b total=%0d error=%b, expected 1 0 1",
                  ifb.drained, ifb.total_pending, ifb.error);
      else passed++;
   endtask

   task automatic test_underflow;
      ifa.committed = 1'b1; ifa.committed_wid = 2'd0;
      step();
      ifa.committed = 1'b0;
      checks++;
      if (ifa.drained !== 1'b1 || ifa.total_pending !== 8'd0 || ifa.error !== 1'b1)
         $display("FAIL underflow: drained=%b total=%0d error=%b, expected 1 0 1",
                  ifa.drained, ifa.total_pending, ifa.error);
      else passed++;
   endtask

   task automatic test_reset_mid;
      ifa.issue_valid = 1'b1; ifa.issue_wid = 2'd3;
      ifb.issue_valid = 2'b11; ifb.issue_wid = 4'b1001;
      step();
      step();
      idle_inputs();
      checks++;
      if (ifa.total_pending !== 8'd2 || ifb.total_pending !== 5'd4 || ifa.error !== 1'b1)
         $display("FAIL midreset_setup: totals=%0d/%0d error_a=%b, expected 2/4 1",
                  ifa.total_pending, ifb.total_pending, ifa.error);
      else passed++;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ifa.drained !== 1'b1 || ifa.pending !== 4'b0000 || ifa.total_pending !== 8'd0 || ifa.error !== 1'b0 ||
          ifb.drained !== 1'b1 || ifb.total_pending !== 5'd0 || ifb.error !== 1'b0)
         $display("FAIL midreset_async: a=%b/%b/%0d/%b b=%b/%0d/%b, expected a=1/0000/0/0 b=1/0/0",
                  ifa.drained, ifa.pending, ifa.total_pending, ifa.error,
                  ifb.drained, ifb.total_pending, ifb.error);
      else passed++;
      #3 reset = 1'b1;
      repeat (10) step();
      checks++;
      if (ifa.drained !== 1'b1 || ifa.total_pending !== 8'd0 || ifa.error !== 1'b0 ||
          ifb.drained !== 1'b1 || ifb.pending !== 4'b0000 || ifb.error !== 1'b0)
         $display("FAIL midreset_idle: a=%b/%0d/%b b=%b/%b/%b, expected a=1/0/0 b=1/0000/0",
                  ifa.drained, ifa.total_pending, ifa.error, ifb.drained, ifb.pending, ifb.error);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_cancel_multilane();
      test_full();
      test_overflow();
      test_underflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
